// File: rtl/hazard_controller.sv
// Hazard control for the 5-stage core: forwarding, load-use/branch stalls and flushes, memory-wait FSM.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_q, timeout_d;
    logic           lw_stall;
    logic           mem_stall;

    // M-stage result is newer than W-stage, so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = FAULT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Ready releases the stall in the same cycle it arrives.
    always_comb begin
        mem_stall = 1'b0;
        unique case (state_q)
            RUN:      mem_stall = MemReqM && !MemReadyM;
            MEM_WAIT: mem_stall = !MemReadyM;
            FAULT:    mem_stall = 1'b1;
            default:  mem_stall = 1'b0;
        endcase
    end

    // A frozen E/M must not be flushed; a held branch re-resolves later.
    always_comb begin
        StallF     = lw_stall | mem_stall;
        StallD     = lw_stall | mem_stall;
        StallE     = mem_stall;
        StallM     = mem_stall;
        FlushW     = mem_stall;
        FlushD     = PCSrcE & ~mem_stall;
        FlushE     = (lw_stall | PCSrcE) & ~mem_stall;
        MemTimeout = timeout_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (FlushE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Randomised and directed bench for hazard_controller against a behavioural model.
module tb_hazard_controller;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW, MemTimeout;
    logic [31:0] StallCount, FlushCount;

    int checks = 0;
    int failures = 0;

    // model state: fault flag, consecutive stalled memory cycles, counters
    logic        m_fault = 1'b0;
    int          m_n = 0;
    logic [31:0] m_sc = '0;
    logic [31:0] m_fc = '0;

    hazard_controller #(.TIMEOUT_CYCLES(T), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lw();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic logic m_ms();
        if (m_fault) return 1'b1;
        if (m_n == 0) return MemReqM && !MemReadyM;
        return !MemReadyM;
    endfunction

    // {FA, FB, SF, SD, SE, SM, FD, FE, FW, MT}
    function automatic logic [11:0] exp_vec();
        logic lw, ms;
        lw = m_lw();
        ms = m_ms();
        return {m_fwd(Rs1E), m_fwd(Rs2E), lw | ms, lw | ms, ms, ms,
                PCSrcE & !ms, (lw | PCSrcE) & !ms, ms, m_fault};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, MemTimeout};
    endfunction

    function automatic logic [31:0] exp_sc();
`ifdef HAZARD_PERF_CNT_EN
        return m_sc;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_fc();
`ifdef HAZARD_PERF_CNT_EN
        return m_fc;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        logic [11:0] e;
        if (!rst) begin
            m_fault = 1'b0;
            m_n = 0;
            m_sc = '0;
            m_fc = '0;
        end else begin
            e = exp_vec();
            if (e[7] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (e[2] && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            if (!m_fault) begin
                if (m_ms()) begin
                    m_n = m_n + 1;
                    if (m_n == T) m_fault = 1'b1;
                end else begin
                    m_n = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), 12'h000);
        end
        checks++;
        if ({StallCount, FlushCount} !== 64'd0) begin
            failures++;
            $display("FAIL reset_counters got=%h/%h exp=0/0", StallCount, FlushCount);
        end
    endtask

    task automatic test_forwarding();
        idle();
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        #1;
        checks++;
        if (ForwardAE !== 2'b10) begin
            failures++;
            $display("FAIL fwd_m_prio got=%b exp=10", ForwardAE);
        end
        RegWriteM = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b01) begin
            failures++;
            $display("FAIL fwd_w got=%b exp=01", ForwardAE);
        end
        Rs1E = 0; RdM = 0; RegWriteM = 1;
        #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            failures++;
            $display("FAIL fwd_x0 got=%b exp=00", ForwardAE);
        end
        for (int i = 0; i < 40; i++) begin
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdM = 5'($urandom_range(0, 3));
            RdW = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            #1;
            checks++;
            if ({ForwardAE, ForwardBE} !== {m_fwd(Rs1E), m_fwd(Rs2E)}) begin
                failures++;
                $display("FAIL fwd_rand got=%b exp=%b",
                         {ForwardAE, ForwardBE}, {m_fwd(Rs1E), m_fwd(Rs2E)});
            end
        end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1;
        checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            failures++;
            $display("FAIL lw_stall got=%b exp=1110", {StallF, StallD, FlushE, FlushD});
        end
        tick();
        idle();
        #1;
        checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b0000) begin
            failures++;
            $display("FAIL lw_one_cycle got=%b exp=0000", {StallF, StallD, FlushE, FlushD});
        end
        ResultSrcE = 2'b01; RdE = 0;
        #1;
        checks++;
        if ({StallF, FlushE} !== 2'b00) begin
            failures++;
            $display("FAIL lw_x0 got=%b exp=00", {StallF, FlushE});
        end
        tick();
        idle();
    endtask

    task automatic test_branch();
        idle();
        PCSrcE = 1;
        #1;
        checks++;
        if ({FlushD, FlushE, StallF} !== 3'b110) begin
            failures++;
            $display("FAIL branch got=%b exp=110", {FlushD, FlushE, StallF});
        end
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        #1;
        checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1111) begin
            failures++;
            $display("FAIL branch_lw got=%b exp=1111", {FlushD, FlushE, StallF, StallD});
        end
        tick();
        idle();
    endtask

    task automatic test_mem_wait();
        idle();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b1111100) begin
                failures++;
                $display("FAIL memwait_c%0d got=%b exp=1111100", i,
                         {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE});
            end
            tick();
        end
        MemReadyM = 1;
        #1;
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b0000011) begin
            failures++;
            $display("FAIL memwait_release got=%b exp=0000011",
                     {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE});
        end
        tick();
        idle();
    endtask

    task automatic test_timeout();
        idle();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < T; i++) begin
            #1;
            checks++;
            if ({MemTimeout, StallF} !== 2'b01) begin
                failures++;
                $display("FAIL timeout_pre%0d got=%b exp=01", i, {MemTimeout, StallF});
            end
            tick();
        end
        MemReadyM = 1; MemReqM = 0; PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (dut_vec() !== 12'b0000_1111_0011) begin
                failures++;
                $display("FAIL fault_hold%0d got=%b exp=%b", i, dut_vec(), 12'b0000_1111_0011);
            end
            tick();
        end
        idle();
        rst = 0;
        tick();
        rst = 1;
        #1;
        checks++;
        if ({MemTimeout, StallF, StallM} !== 3'b000) begin
            failures++;
            $display("FAIL fault_reset got=%b exp=000", {MemTimeout, StallF, StallM});
        end
        MemReqM = 1; MemReadyM = 0;
        tick();
        tick();
        rst = 0;
        tick();
        rst = 1; MemReqM = 0;
        #1;
        checks++;
        if (StallF !== 1'b0) begin
            failures++;
            $display("FAIL wait_reset got=%b exp=0", StallF);
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3));
            RdM = 5'($urandom_range(0, 3));
            RdW = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            MemReqM = 1'($urandom);
            MemReadyM = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rand_out%0d got=%b exp=%b", i, dut_vec(), exp_vec());
            end
            checks++;
            if ({StallCount, FlushCount} !== {exp_sc(), exp_fc()}) begin
                failures++;
                $display("FAIL rand_cnt%0d got=%0d/%0d exp=%0d/%0d", i,
                         StallCount, FlushCount, exp_sc(), exp_fc());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_perf();
        logic [31:0] want_s, want_f;
`ifdef HAZARD_PERF_CNT_EN
        want_s = 32'd3;
        want_f = 32'd5;
`else
        want_s = 32'd0;
        want_f = 32'd0;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
            tick();
            idle();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            PCSrcE = 1;
            tick();
            idle();
            tick();
        end
        #1;
        checks++;
        if ({StallCount, FlushCount} !== {want_s, want_f}) begin
            failures++;
            $display("FAIL perf_cnt got=%0d/%0d exp=%0d/%0d",
                     StallCount, FlushCount, want_s, want_f);
        end
    endtask

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_random();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
